// File: rtl/shift_seq_pkg.sv
// Shared ALU shift-path definitions.
//   WIDTH / SHAMT_W : datapath and shift-amount widths
//   K_W             : width of the stage index (0 .. SHAMT_W-1)
//   OP_SLL / OP_SRA : shift opcode encoding
//   state_t         : sequencer state encoding
package shift_seq_pkg;

    localparam int WIDTH   = 32;
    localparam int SHAMT_W = 5;
    localparam int K_W     = $clog2(SHAMT_W);

    localparam logic OP_SLL = 1'b0;
    localparam logic OP_SRA = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_DONE  = 2'd2
    } state_t;

endpackage

// File: rtl/shift_seq_stage.sv
// One binary stage of the shift path: shifts by 2^k when enabled,
// otherwise passes the word through. Purely combinational.
//   w   in  WIDTH  word entering the stage
//   k   in  K_W    stage index, 0..SHAMT_W-1 (distance 2^k)
//   op  in  1      OP_SLL (zero fill) or OP_SRA (sign fill)
//   en  in  1      apply the stage when high
//   y   out WIDTH  shifted or passed-through word
module shift_stage
    import shift_seq_pkg::*;
(
    input  logic [WIDTH-1:0] w,
    input  logic [K_W-1:0]   k,
    input  logic             op,
    input  logic             en,
    output logic [WIDTH-1:0] y
);

    // Fixed-distance stages, identical to the combinational barrel shifter.
    logic [WIDTH-1:0] sll_st [SHAMT_W];
    logic [WIDTH-1:0] sra_st [SHAMT_W];

    for (genvar i = 0; i < SHAMT_W; i++) begin : g_st
        assign sll_st[i] = w << (2 ** i);
        assign sra_st[i] = $signed(w) >>> (2 ** i);
    end

    always_comb begin
        y = w;
        if (en) begin
            case (k)
                3'd0:    y = (op == OP_SRA) ? sra_st[0] : sll_st[0];
                3'd1:    y = (op == OP_SRA) ? sra_st[1] : sll_st[1];
                3'd2:    y = (op == OP_SRA) ? sra_st[2] : sll_st[2];
                3'd3:    y = (op == OP_SRA) ? sra_st[3] : sll_st[3];
                3'd4:    y = (op == OP_SRA) ? sra_st[4] : sll_st[4];
                default: y = w;
            endcase
        end
    end

endmodule

// File: rtl/shift_seq.sv
// Multicycle SLL/SRA unit: resolves the shift amount one binary stage per
// cycle, 16 down to 1, then pulses result_rdy for one cycle.
//   clock         in  1      rising-edge clock
//   reset         in  1      synchronous active-low reset
//   start         in  1      request strobe, accepted in IDLE or DONE
//   op            in  1      0 = SLL, 1 = SRA
//   data_operand  in  WIDTH  value to shift
//   shamt         in  SHAMT_W shift amount
//   busy          out 1      high while in SHIFT
//   result_rdy    out 1      one-cycle pulse in DONE
//   data_result   out WIDTH  last completed result, held until next completion
//
// state | meaning
// IDLE  | waiting for start
// SHIFT | applying stage k (4 down to 0), one per cycle
// DONE  | result valid, result_rdy high; start here chains a new request
module shift_seq #(
    parameter int WIDTH   = shift_seq_pkg::WIDTH,   // only 32 supported
    parameter int SHAMT_W = shift_seq_pkg::SHAMT_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic               op,
    input  logic [WIDTH-1:0]   data_operand,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               busy,
    output logic               result_rdy,
    output logic [WIDTH-1:0]   data_result
);

    localparam int K_W = shift_seq_pkg::K_W;
    localparam logic [K_W-1:0] K_TOP = K_W'(SHAMT_W - 1);

    shift_seq_pkg::state_t state;
    logic [K_W-1:0]     k;
    logic [WIDTH-1:0]   w;
    logic [SHAMT_W-1:0] shamt_q;
    logic               op_q;
    logic [WIDTH-1:0]   stage_out;

    shift_stage u_stage (
        .w  (w),
        .k  (k),
        .op (op_q),
        .en (shamt_q[k]),
        .y  (stage_out)
    );

    // busy/result_rdy are registered alongside the state so they are pure
    // state decodes with no path from the inputs.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state       <= shift_seq_pkg::ST_IDLE;
            k           <= K_TOP;
            w           <= '0;
            shamt_q     <= '0;
            op_q        <= shift_seq_pkg::OP_SLL;
            data_result <= '0;
            busy        <= 1'b0;
            result_rdy  <= 1'b0;
        end else begin
            case (state)
                shift_seq_pkg::ST_IDLE,
                shift_seq_pkg::ST_DONE: begin
                    result_rdy <= 1'b0;
                    if (start) begin
                        w       <= data_operand;
                        shamt_q <= shamt;
                        op_q    <= op;
                        k       <= K_TOP;
                        state   <= shift_seq_pkg::ST_SHIFT;
                        busy    <= 1'b1;
                    end else begin
                        state <= shift_seq_pkg::ST_IDLE;
                        busy  <= 1'b0;
                    end
                end
                shift_seq_pkg::ST_SHIFT: begin
                    w <= stage_out;
                    if (k == '0) begin
                        data_result <= stage_out;
                        state       <= shift_seq_pkg::ST_DONE;
                        busy        <= 1'b0;
                        result_rdy  <= 1'b1;
                    end else begin
                        k <= k - 1'b1;
                    end
                end
                default: begin
                    state      <= shift_seq_pkg::ST_IDLE;
                    busy       <= 1'b0;
                    result_rdy <= 1'b0;
                end
            endcase
        end
    end

endmodule
